// File: rtl/ninjakun_pkg.sv
// ninjakun_pkg -- shared definitions for the Ninja-Kun family bus decoder.
//
// Holds the hardware-variant encodings, the chip-select index constants,
// the decoder FSM state constants and the per-variant, per-CPU memory map
// (base/mask per region). Used by ninjakun_regdec, ninjakun_busdec_if and
// ninjakun_busdec.
//
// Optional feature macro (used by the importing files): NINJAKUN_BUSDEC_FAULT_EN.
package ninjakun_pkg;

    typedef enum logic [1:0] {
        HW_NINJAKUN = 2'd0,
        HW_RAIDERS5 = 2'd1,
        HW_NOVA2001 = 2'd2,
        HW_PKUNWAR  = 2'd3
    } hwtype_t;

    // Chip-select bit positions.
    localparam int CS_PSG      = 0;
    localparam int CS_FGV      = 1;
    localparam int CS_BGV      = 2;
    localparam int CS_SPA      = 3;
    localparam int CS_PAL      = 4;
    localparam int CS_SCRX     = 5;
    localparam int CS_SCRY     = 6;
    localparam int NUM_REGIONS = 7;

    // Decoder FSM states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A region hits when (adr & mask) == base and the entry is enabled.
    typedef struct packed {
        logic        en;
        logic [15:0] base;
        logic [15:0] mask;
    } region_t;

    localparam region_t REG_NONE = '{en: 1'b0, base: 16'h0000, mask: 16'h0000};

    function automatic region_t mk(input logic [15:0] b, input logic [15:0] m);
        return '{en: 1'b1, base: b, mask: m};
    endfunction

    // Memory map. Ninja-Kun shares one map between both CPUs; Raiders5 has
    // a reduced second-CPU map; Nova2001 and Penguin-Kun Wars have no
    // second-CPU map, so CPU1 decodes to nothing there.
    function automatic region_t region_of(input hwtype_t hw, input logic cpu, input int idx);
        region_t r;
        r = REG_NONE;
        case (hw)
            HW_NINJAKUN: begin
                case (idx)
                    CS_PSG:  r = mk(16'hA000, 16'hFFFC);
                    CS_FGV:  r = mk(16'hC000, 16'hF800);
                    CS_BGV:  r = mk(16'hC800, 16'hF800);
                    CS_SPA:  r = mk(16'hD000, 16'hF800);
                    CS_PAL:  r = mk(16'hD800, 16'hFC00);
                    CS_SCRX: r = mk(16'hA400, 16'hFFFF);
                    CS_SCRY: r = mk(16'hA401, 16'hFFFF);
                    default: r = REG_NONE;
                endcase
            end
            HW_RAIDERS5: begin
                if (!cpu) begin
                    case (idx)
                        CS_PSG:  r = mk(16'hA000, 16'hFFFC);
                        CS_FGV:  r = mk(16'h8000, 16'hF800);
                        CS_BGV:  r = mk(16'h8800, 16'hF800);
                        CS_SPA:  r = mk(16'h9000, 16'hF800);
                        CS_PAL:  r = mk(16'hD000, 16'hFC00);
                        CS_SCRX: r = mk(16'hC000, 16'hFFFF);
                        CS_SCRY: r = mk(16'hC001, 16'hFFFF);
                        default: r = REG_NONE;
                    endcase
                end else begin
                    case (idx)
                        CS_PSG:  r = mk(16'hA000, 16'hFFFC);
                        CS_FGV:  r = mk(16'h8000, 16'hF800);
                        CS_SCRX: r = mk(16'hE000, 16'hFFFF);
                        CS_SCRY: r = mk(16'hE001, 16'hFFFF);
                        default: r = REG_NONE;
                    endcase
                end
            end
            HW_NOVA2001: begin
                if (!cpu) begin
                    case (idx)
                        CS_PSG:  r = mk(16'hC000, 16'hFFFE);
                        CS_FGV:  r = mk(16'hA000, 16'hF800);
                        CS_BGV:  r = mk(16'hA800, 16'hF800);
                        CS_SPA:  r = mk(16'hB000, 16'hF800);
                        CS_PAL:  r = mk(16'hB800, 16'hFC00);
                        CS_SCRX: r = mk(16'hBFFE, 16'hFFFF);
                        CS_SCRY: r = mk(16'hBFFF, 16'hFFFF);
                        default: r = REG_NONE;
                    endcase
                end
            end
            HW_PKUNWAR: begin
                if (!cpu) begin
                    case (idx)
                        CS_PSG:  r = mk(16'hA000, 16'hFFFE);
                        CS_FGV:  r = mk(16'h8000, 16'hF800);
                        CS_BGV:  r = mk(16'h8800, 16'hF800);
                        CS_SPA:  r = mk(16'h9000, 16'hF800);
                        CS_PAL:  r = mk(16'hA800, 16'hFC00);
                        default: r = REG_NONE;
                    endcase
                end
            end
            default: r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ninjakun_busdec_if.sv
// ninjakun_busdec_if -- CPU-side bus of the Ninja-Kun bus decoder.
//
// Signals: hwtype (variant), cp0adr/cp1adr (addresses), cp0req/cp1req
// (memory-cycle strobes), cs (one-hot chip select), csown (owning CPU),
// cp0wait/cp1wait (stall requests); fault/faultcnt only when
// NINJAKUN_BUSDEC_FAULT_EN is defined.
// Modports: master = CPU/stimulus side, slave = decoder side.
//
// Handshake: cpNreq is the request (valid); ~cpNwait acts as ready. A CPU
// holds cpNreq and its address while cpNwait is high; the cycle in which
// cpNreq is high and cpNwait is low completes that CPU's access, and the
// CPU ends it by dropping cpNreq.
interface ninjakun_busdec_if #(parameter int NCS = 7);
    ninjakun_pkg::hwtype_t hwtype;
    logic [15:0]           cp0adr;
    logic [15:0]           cp1adr;
    logic                  cp0req;
    logic                  cp1req;
    logic [NCS-1:0]        cs;
    logic                  csown;
    logic                  cp0wait;
    logic                  cp1wait;
`ifdef NINJAKUN_BUSDEC_FAULT_EN
    logic                  fault;
    logic [7:0]            faultcnt;
`endif

    modport master (
        output hwtype, cp0adr, cp1adr, cp0req, cp1req,
        input  cs, csown, cp0wait, cp1wait
`ifdef NINJAKUN_BUSDEC_FAULT_EN
        , input fault, faultcnt
`endif
    );

    modport slave (
        input  hwtype, cp0adr, cp1adr, cp0req, cp1req,
        output cs, csown, cp0wait, cp1wait
`ifdef NINJAKUN_BUSDEC_FAULT_EN
        , output fault, faultcnt
`endif
    );
endinterface

// File: rtl/ninjakun_regdec.sv
// ninjakun_regdec -- combinational region decoder for one CPU.
//
// Ports: hwtype (variant), adr (CPU address), hit (address falls in some
// region), sel (one-hot region select, NCS wide).
// Parameters: CPU selects the CPU0/CPU1 map, NCS the select width.
// Feature macro NINJAKUN_BUSDEC_FAULT_EN does not affect this block.
module ninjakun_regdec
    import ninjakun_pkg::*;
#(
    parameter bit CPU = 1'b0,
    parameter int NCS = 7
) (
    input  hwtype_t        hwtype,
    input  logic [15:0]    adr,
    output logic           hit,
    output logic [NCS-1:0] sel
);

    logic [NCS-1:0] raw;

    for (genvar i = 0; i < NCS; i++) begin : g_reg
        region_t rg;
        assign rg     = region_of(hwtype, CPU, i);
        assign raw[i] = rg.en && ((adr & rg.mask) == rg.base);
    end

    // The map has no overlaps, but the lowest index still wins so that sel
    // stays one-hot even if a future map entry overlaps another.
    always_comb begin
        sel = '0;
        for (int i = NCS - 1; i >= 0; i--) begin
            if (raw[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end

    assign hit = |raw;

endmodule

// File: rtl/ninjakun_busdec.sv
// ninjakun_busdec -- two-CPU bus decoder / arbiter with wait-state insertion.
//
// Ports: clk, rst_n (async active-low), bus (ninjakun_busdec_if.slave:
// hwtype, cp0adr/cp1adr, cp0req/cp1req in; cs, csown, cp0wait/cp1wait out,
// plus fault/faultcnt when NINJAKUN_BUSDEC_FAULT_EN is defined),
// dbg_state (current FSM state).
// Parameters: WAITS (0..15) extra wait cycles per access, NCS select width.
//
// FSM: IDLE -> ACC on a hitting request (owner, cs registered), ACC for
// WAITS+1 cycles, DONE until the owner drops its request, back to IDLE.
module ninjakun_busdec
    import ninjakun_pkg::*;
#(
    parameter int WAITS = 1,
    parameter int NCS   = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    ninjakun_busdec_if.slave   bus,
    output logic [1:0]         dbg_state
);

    localparam logic [3:0] WAITS_L = WAITS[3:0];

    logic           hit0, hit1;
    logic [NCS-1:0] sel0, sel1;
    logic [1:0]     state;
    logic [3:0]     cnt;
    logic           rr_cpu1;      // CPU1 has priority on the next tie
    logic           own_q;
    logic [NCS-1:0] cs_q;
    logic           req_hit0, req_hit1;
    logic           owner_req;
    logic           grant_cpu1;
    logic           in_done;

    ninjakun_regdec #(.CPU(1'b0), .NCS(NCS)) u_dec0 (
        .hwtype (bus.hwtype),
        .adr    (bus.cp0adr),
        .hit    (hit0),
        .sel    (sel0)
    );

    ninjakun_regdec #(.CPU(1'b1), .NCS(NCS)) u_dec1 (
        .hwtype (bus.hwtype),
        .adr    (bus.cp1adr),
        .hit    (hit1),
        .sel    (sel1)
    );

    // Requests that miss every region never reach the arbiter.
    assign req_hit0   = bus.cp0req & hit0;
    assign req_hit1   = bus.cp1req & hit1;
    assign owner_req  = own_q ? bus.cp1req : bus.cp0req;
    assign grant_cpu1 = req_hit1 & (~req_hit0 | rr_cpu1);
    assign in_done    = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cs_q    <= '0;
            own_q   <= 1'b0;
            cnt     <= 4'd0;
            rr_cpu1 <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_hit0 || req_hit1) begin
                        state   <= ST_ACC;
                        own_q   <= grant_cpu1;
                        cs_q    <= grant_cpu1 ? sel1 : sel0;
                        cnt     <= 4'd0;
                        rr_cpu1 <= ~grant_cpu1;
                    end
                end
                ST_ACC: begin
                    // An owner that abandons its cycle releases the bus at once.
                    if (!owner_req) begin
                        state <= ST_IDLE;
                        cs_q  <= '0;
                        cnt   <= 4'd0;
                    end else if (cnt == WAITS_L) begin
                        state <= ST_DONE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    // Always pass through IDLE so a pending request is seen there.
                    if (!owner_req) begin
                        state <= ST_IDLE;
                        cs_q  <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cs_q  <= '0;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.cs      = cs_q;
    assign bus.csown   = own_q;
    // Only the owner in DONE is released; everyone else hitting keeps stalling.
    assign bus.cp0wait = req_hit0 & ~(~own_q & in_done);
    assign bus.cp1wait = req_hit1 & ~(own_q & in_done);
    assign dbg_state   = state;

`ifdef NINJAKUN_BUSDEC_FAULT_EN
    logic       fault_q;
    logic [7:0] fcnt_q;
    logic       same_hit;

    // Both CPUs hitting the same region while an access is in flight.
    assign same_hit = req_hit0 & req_hit1 & (sel0 == sel1) & (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
            fcnt_q  <= 8'd0;
        end else if (same_hit) begin
            fault_q <= 1'b1;
            if (fcnt_q != 8'hFF) begin
                fcnt_q <= fcnt_q + 8'd1;
            end
        end
    end

    assign bus.fault    = fault_q;
    assign bus.faultcnt = fcnt_q;
`endif

endmodule

// File: tb/tb_ninjakun_busdec.sv
// tb_ninjakun_busdec -- self-checking bench for ninjakun_busdec.
// Two instances (WAITS=1 and WAITS=3) share one stimulus stream; a
// range-based reference model predicts every output each cycle.
// Also checks fault/faultcnt when NINJAKUN_BUSDEC_FAULT_EN is defined.
module tb_ninjakun_busdec;
    import ninjakun_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    hwtype_t     hw;
    logic [15:0] a0, a1;
    logic        r0, r1;

    ninjakun_busdec_if #(.NCS(7)) bus_a ();
    ninjakun_busdec_if #(.NCS(7)) bus_b ();

    assign bus_a.hwtype = hw;  assign bus_b.hwtype = hw;
    assign bus_a.cp0adr = a0;  assign bus_b.cp0adr = a0;
    assign bus_a.cp1adr = a1;  assign bus_b.cp1adr = a1;
    assign bus_a.cp0req = r0;  assign bus_b.cp0req = r0;
    assign bus_a.cp1req = r1;  assign bus_b.cp1req = r1;

    logic [1:0] st_o [2];

    ninjakun_busdec #(.WAITS(1), .NCS(7)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .dbg_state(st_o[0]));
    ninjakun_busdec #(.WAITS(3), .NCS(7)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .dbg_state(st_o[1]));

    logic [6:0] cs_o [2];
    logic       own_o [2], w0_o [2], w1_o [2];
    assign cs_o[0] = bus_a.cs;      assign cs_o[1] = bus_b.cs;
    assign own_o[0] = bus_a.csown;  assign own_o[1] = bus_b.csown;
    assign w0_o[0] = bus_a.cp0wait; assign w0_o[1] = bus_b.cp0wait;
    assign w1_o[0] = bus_a.cp1wait; assign w1_o[1] = bus_b.cp1wait;
`ifdef NINJAKUN_BUSDEC_FAULT_EN
    logic       flt_o [2];
    logic [7:0] fc_o [2];
    assign flt_o[0] = bus_a.fault;   assign flt_o[1] = bus_b.fault;
    assign fc_o[0] = bus_a.faultcnt; assign fc_o[1] = bus_b.faultcnt;
`endif

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    localparam int W = 32;
    logic [W-1:0] exp_q[$];
    int wt [2] = '{1, 3};
    int m_busy [2], m_own [2], m_reg [2], m_age [2], m_prio [2], m_flt [2], m_fcnt [2];

    function automatic bit rng(input logic [15:0] a, input logic [15:0] lo, input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    // Region index of an address, -1 on a miss, written as address ranges.
    function automatic int dec(input hwtype_t h, input int cpu, input logic [15:0] a);
        if (h == HW_NINJAKUN || (h == HW_RAIDERS5 && cpu == 0)) begin
            if (rng(a, 16'hA000, 16'hA003)) return 0;
        end
        if (h == HW_NINJAKUN) begin
            if (rng(a, 16'hC000, 16'hC7FF)) return 1;
            if (rng(a, 16'hC800, 16'hCFFF)) return 2;
            if (rng(a, 16'hD000, 16'hD7FF)) return 3;
            if (rng(a, 16'hD800, 16'hDBFF)) return 4;
            if (a == 16'hA400) return 5;
            if (a == 16'hA401) return 6;
        end else if (h == HW_RAIDERS5 && cpu == 0) begin
            if (rng(a, 16'h8000, 16'h87FF)) return 1;
            if (rng(a, 16'h8800, 16'h8FFF)) return 2;
            if (rng(a, 16'h9000, 16'h97FF)) return 3;
            if (rng(a, 16'hD000, 16'hD3FF)) return 4;
            if (a == 16'hC000) return 5;
            if (a == 16'hC001) return 6;
        end else if (h == HW_RAIDERS5) begin
            if (rng(a, 16'hA000, 16'hA003)) return 0;
            if (rng(a, 16'h8000, 16'h87FF)) return 1;
            if (a == 16'hE000) return 5;
            if (a == 16'hE001) return 6;
        end else if (h == HW_NOVA2001 && cpu == 0) begin
            if (rng(a, 16'hC000, 16'hC001)) return 0;
            if (rng(a, 16'hA000, 16'hA7FF)) return 1;
            if (rng(a, 16'hA800, 16'hAFFF)) return 2;
            if (rng(a, 16'hB000, 16'hB7FF)) return 3;
            if (rng(a, 16'hB800, 16'hBBFF)) return 4;
            if (a == 16'hBFFE) return 5;
            if (a == 16'hBFFF) return 6;
        end else if (h == HW_PKUNWAR && cpu == 0) begin
            if (rng(a, 16'hA000, 16'hA001)) return 0;
            if (rng(a, 16'h8000, 16'h87FF)) return 1;
            if (rng(a, 16'h8800, 16'h8FFF)) return 2;
            if (rng(a, 16'h9000, 16'h97FF)) return 3;
            if (rng(a, 16'hA800, 16'hABFF)) return 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_own[k] = 0; m_reg[k] = 0; m_age[k] = 0;
            m_prio[k] = 0; m_flt[k] = 0; m_fcnt[k] = 0;
        end
    endtask

    // Expected outputs for instance k from model state and present inputs.
    task automatic push_expect(input int k);
        int g0, g1;
        bit done;
        logic [W-1:0] e;
        g0 = r0 ? dec(hw, 0, a0) : -1;
        g1 = r1 ? dec(hw, 1, a1) : -1;
        done = (m_busy[k] != 0) && (m_age[k] > wt[k]);
        e = '0;
        e[6:0]   = (m_busy[k] != 0) ? 7'(1 << m_reg[k]) : 7'd0;
        e[7]     = (m_own[k] != 0);
        e[8]     = (g0 >= 0) && !(done && m_own[k] == 0);
        e[9]     = (g1 >= 0) && !(done && m_own[k] == 1);
        e[11:10] = (m_busy[k] == 0) ? ST_IDLE : (done ? ST_DONE : ST_ACC);
        e[19:12] = 8'(m_fcnt[k]);
        e[20]    = (m_flt[k] != 0);
        exp_q.push_back(e);
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        int g0, g1, win;
        g0 = r0 ? dec(hw, 0, a0) : -1;
        g1 = r1 ? dec(hw, 1, a1) : -1;
        for (int k = 0; k < 2; k++) begin
            if (m_busy[k] != 0) begin
                if (g0 >= 0 && g1 >= 0 && g0 == g1) begin
                    m_flt[k] = 1;
                    if (m_fcnt[k] < 255) m_fcnt[k]++;
                end
                if (!((m_own[k] != 0) ? r1 : r0)) m_busy[k] = 0;
                else if (m_age[k] <= wt[k]) m_age[k]++;
            end else if (g0 >= 0 || g1 >= 0) begin
                win = (g0 >= 0 && g1 >= 0) ? m_prio[k] : ((g1 >= 0) ? 1 : 0);
                m_busy[k] = 1;
                m_own[k]  = win;
                m_reg[k]  = (win != 0) ? g1 : g0;
                m_age[k]  = 0;
                m_prio[k] = 1 - win;
            end
        end
        push_expect(0);
        push_expect(1);
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] e;
        for (int k = 0; k < 2; k++) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("cs[%0d]", k),    32'(cs_o[k]),  32'(e[6:0]));
                chk($sformatf("csown[%0d]", k), 32'(own_o[k]), 32'(e[7]));
                chk($sformatf("wait0[%0d]", k), 32'(w0_o[k]),  32'(e[8]));
                chk($sformatf("wait1[%0d]", k), 32'(w1_o[k]),  32'(e[9]));
                chk($sformatf("state[%0d]", k), 32'(st_o[k]),  32'(e[11:10]));
`ifdef NINJAKUN_BUSDEC_FAULT_EN
                chk($sformatf("fault[%0d]", k),    32'(flt_o[k]), 32'(e[20]));
                chk($sformatf("faultcnt[%0d]", k), 32'(fc_o[k]),  32'(e[19:12]));
`endif
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_now();
        push_expect(0);
        push_expect(1);
        check_outputs();
    endtask

    typedef struct {
        hwtype_t     hw;
        int          cpu;
        logic [15:0] adr;
        logic [6:0]  exp_cs;
    } vec_t;

    logic [15:0] pool [20] = '{16'hC000, 16'hC800, 16'hD000, 16'hD800, 16'hA000,
                               16'hA001, 16'h8000, 16'h8800, 16'h9000, 16'hE000,
                               16'hE001, 16'hC001, 16'hBFFE, 16'hBFFF, 16'hB800,
                               16'hA800, 16'h4000, 16'hB000, 16'hA400, 16'hA401};

    function automatic logic [15:0] pick();
        if ($urandom_range(0, 7) == 0) return 16'($urandom);
        return pool[$urandom_range(0, 19)];
    endfunction

    vec_t vt [14];

    initial begin
        vt[0]  = '{HW_NINJAKUN, 0, 16'hA002, 7'b0000001};
        vt[1]  = '{HW_NINJAKUN, 0, 16'hC123, 7'b0000010};
        vt[2]  = '{HW_NINJAKUN, 1, 16'hC800, 7'b0000100};
        vt[3]  = '{HW_NINJAKUN, 0, 16'hD7FF, 7'b0001000};
        vt[4]  = '{HW_NINJAKUN, 1, 16'hDBFF, 7'b0010000};
        vt[5]  = '{HW_NINJAKUN, 0, 16'hA401, 7'b1000000};
        vt[6]  = '{HW_RAIDERS5, 1, 16'hE001, 7'b1000000};
        vt[7]  = '{HW_RAIDERS5, 1, 16'hC000, 7'b0000000};
        vt[8]  = '{HW_NOVA2001, 0, 16'hBFFE, 7'b0100000};
        vt[9]  = '{HW_NOVA2001, 1, 16'hA000, 7'b0000000};
        vt[10] = '{HW_PKUNWAR,  0, 16'h4000, 7'b0000000};
        vt[11] = '{HW_PKUNWAR,  0, 16'hA9FF, 7'b0010000};
        vt[12] = '{HW_PKUNWAR,  1, 16'h8000, 7'b0000000};
        vt[13] = '{HW_NOVA2001, 0, 16'hB900, 7'b0010000};

        // reset state
        rst_n = 1'b0; hw = HW_NINJAKUN; a0 = '0; a1 = '0; r0 = 1'b0; r1 = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_now();
        chk("reset_cs", 32'(cs_o[0]), 32'd0);
        chk("reset_state", 32'(st_o[1]), 32'(ST_IDLE));
        rst_n = 1'b1;
        cycle();

        // simultaneous requests, RAIDERS5: CPU0 first, CPU1 after release
        hw = HW_RAIDERS5; a0 = 16'h8800; a1 = 16'hE000; r0 = 1'b1; r1 = 1'b1;
        #1;
        chk("tie_wait0_idle", 32'(w0_o[0]), 32'd1);
        chk("tie_wait1_idle", 32'(w1_o[0]), 32'd1);
        cycle();
        chk("tie_cs_first", 32'(cs_o[0]), 32'b0000100);
        chk("tie_own_first", 32'(own_o[0]), 32'd0);
        chk("tie_wait1_acc", 32'(w1_o[0]), 32'd1);
        cycle(); cycle();
        chk("tie_wait0_done", 32'(w0_o[0]), 32'd0);
        chk("tie_wait1_done", 32'(w1_o[0]), 32'd1);
        r0 = 1'b0;
        cycle();
        chk("tie_release_cs", 32'(cs_o[0]), 32'd0);
        cycle();
        chk("tie_cs_second", 32'(cs_o[0]), 32'b0100000);
        chk("tie_own_second", 32'(own_o[0]), 32'd1);
        r1 = 1'b0;
        cycle(); cycle();

        // single access, NINJAKUN, WAITS=1
        hw = HW_NINJAKUN; a0 = 16'hC000; r0 = 1'b1;
        #1;
        chk("fgv_wait_idle", 32'(w0_o[0]), 32'd1);
        cycle();
        chk("fgv_cs", 32'(cs_o[0]), 32'b0000010);
        chk("fgv_wait_acc1", 32'(w0_o[0]), 32'd1);
        cycle();
        chk("fgv_wait_acc2", 32'(w0_o[0]), 32'd1);
        cycle();
        chk("fgv_wait_done", 32'(w0_o[0]), 32'd0);
        chk("fgv_state_done", 32'(st_o[0]), 32'(ST_DONE));
        // address/variant changes while owning must not move cs
        a0 = 16'h4000; hw = HW_NOVA2001;
        cycle();
        chk("fgv_cs_held", 32'(cs_o[0]), 32'b0000010);
        r0 = 1'b0;
        cycle(); cycle();

        // miss never stalls, never selects
        hw = HW_PKUNWAR; a0 = 16'h4000; r0 = 1'b1;
        #1;
        chk("miss_wait", 32'(w0_o[0]), 32'd0);
        repeat (3) cycle();
        chk("miss_cs", 32'(cs_o[0]), 32'd0);
        chk("miss_state", 32'(st_o[1]), 32'(ST_IDLE));
        r0 = 1'b0;
        cycle();

        // abort during ACC on the WAITS=3 instance
        hw = HW_NINJAKUN; a0 = 16'hD000; r0 = 1'b1;
        cycle(); cycle();
        chk("abort_state_acc", 32'(st_o[1]), 32'(ST_ACC));
        r0 = 1'b0;
        cycle();
        chk("abort_cs", 32'(cs_o[1]), 32'd0);
        chk("abort_state_idle", 32'(st_o[1]), 32'(ST_IDLE));
        cycle();

        // decode table
        for (int i = 0; i < 14; i++) begin
            hw = vt[i].hw;
            if (vt[i].cpu == 0) begin a0 = vt[i].adr; r0 = 1'b1; end
            else begin a1 = vt[i].adr; r1 = 1'b1; end
            cycle();
            chk($sformatf("table%0d_cs", i), 32'(cs_o[0]), 32'(vt[i].exp_cs));
            r0 = 1'b0; r1 = 1'b0;
            cycle(); cycle();
        end

        // randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 63) == 0) hw = hwtype_t'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) r0 = ~r0;
            if ($urandom_range(0, 4) == 0) r1 = ~r1;
            if ($urandom_range(0, 3) == 0) a0 = pick();
            if ($urandom_range(0, 3) == 0) a1 = pick();
            cycle();
        end
        r0 = 1'b0; r1 = 1'b0;
        cycle(); cycle();

        // reset during DONE with CPU1 owning
        hw = HW_NINJAKUN; a1 = 16'hC800; r1 = 1'b1;
        repeat (6) cycle();
        chk("rst1_pre_state", 32'(st_o[1]), 32'(ST_DONE));
        chk("rst1_pre_own", 32'(own_o[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst1_cs", 32'(cs_o[1]), 32'd0);
        chk("rst1_own", 32'(own_o[1]), 32'd0);
        chk("rst1_wait1", 32'(w1_o[0]), 32'd1);
        check_now();
        #1 rst_n = 1'b1; r1 = 1'b0;
        cycle(); cycle();

        // reset during DONE with CPU0 owning, then a tie goes to CPU0
        a0 = 16'hC000; r0 = 1'b1;
        repeat (6) cycle();
        chk("rst2_pre_state", 32'(st_o[1]), 32'(ST_DONE));
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst2_cs", 32'(cs_o[0]), 32'd0);
        check_now();
        a1 = 16'hC800; r1 = 1'b1;
        #1 rst_n = 1'b1;
        cycle();
        chk("rst2_tie_own_a", 32'(own_o[0]), 32'd0);
        chk("rst2_tie_own_b", 32'(own_o[1]), 32'd0);
        chk("rst2_tie_cs", 32'(cs_o[0]), 32'b0000010);
        r0 = 1'b0;
        cycle(); cycle();
        r1 = 1'b0;
        repeat (3) cycle();

        // sustained same-region overlap
        a0 = 16'hC000; a1 = 16'hC000; r0 = 1'b1; r1 = 1'b1;
        repeat (301) cycle();
`ifdef NINJAKUN_BUSDEC_FAULT_EN
        chk("overlap_fault", 32'(flt_o[0]), 32'd1);
        chk("overlap_faultcnt", 32'(fc_o[0]), 32'd255);
        chk("overlap_faultcnt_b", 32'(fc_o[1]), 32'd255);
`endif
        chk("overlap_wait1", 32'(w1_o[0]), 32'd1);
        r0 = 1'b0; r1 = 1'b0;
        cycle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ninjakun_busdec.md
NINJAKUN_BUSDEC -- requirements
Module: ninjakun_busdec

Interface
REQ-001 Parameter WAITS, default 1, meaning wait-state cycles per granted access, range 0..15.
REQ-002 Parameter NCS, default 7, meaning chip-select vector width; index order is PSG, FGV, BGV, SPA, PAL, SCRX, SCRY.
REQ-003 CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 HWTYPE  input  2  hardware variant: NINJAKUN, RAIDERS5, NOVA2001 or PKUNWAR.
REQ-006 CP0ADR, CP1ADR  input  16 each  CPU0 and CPU1 address.
REQ-007 CP0REQ, CP1REQ  input  1 each  memory-cycle strobe, active-high.
REQ-008 CS  output  NCS  registered one-hot chip select for the granted access.
REQ-009 CSOWN  output  1  CPU index owning CS, 0 or 1.
REQ-010 CP0WAIT, CP1WAIT  output  1 each  stall request to each CPU, active-high.

Function
REQ-011 Each CPU address SHALL be decoded combinationally into a region hit per the per-HWTYPE, per-CPU memory map held in the package.
- Variants without a second-CPU map decode CPU1 to no region.
REQ-012 A request that hits no region SHALL never assert that CPU's WAIT and SHALL not enter arbitration.
REQ-013 The FSM SHALL have the states IDLE, ACC and DONE.
REQ-014 IDLE->ACC SHALL occur on the edge where at least one hitting request is present.
- Owner, region and CS are registered on that edge.
- A single requester wins.
- On simultaneous requests the winner is the CPU not granted last; round-robin priority resets to CPU0.
REQ-015 ACC SHALL last exactly WAITS+1 cycles, counted by a 4-bit counter, then go to DONE.
- WAITS=0 gives a single ACC cycle.
REQ-016 DONE SHALL hold until the owner's REQ is low, then go to IDLE; CS clears on that same edge.
REQ-017 CS SHALL be non-zero only in ACC and DONE and SHALL carry exactly one set bit.
REQ-018 CPnWAIT SHALL equal CPnREQ AND hit_n AND NOT (CSOWN==n AND state==DONE), combinationally.
- The loser therefore stalls through the whole owner access.
REQ-019 If the owner's REQ drops during ACC, the FSM SHALL return to IDLE on the next edge and CS SHALL clear.
REQ-020 A request pending while in DONE SHALL be granted via IDLE, never sooner than one IDLE cycle after DONE.
REQ-021 Owner address and HWTYPE changes during ACC or DONE SHALL NOT alter the registered CS.

Reset
REQ-022 Asserting RST_N low SHALL immediately force:
- state IDLE, CS all zero, CSOWN 0, counter 0, round-robin to CPU0.
REQ-023 A reset mid-access SHALL abort the access; WAIT outputs then follow REQ-018 with state IDLE.

Configuration
REQ-024 With NINJAKUN_BUSDEC_FAULT_EN defined, the block SHALL add:
- output FAULT (1 bit): sticky, set when both requests hit the same region within one cycle while in ACC or DONE, cleared only by reset.
- output FAULTCNT (8 bits): saturating count of such cycles.
REQ-025 Without NINJAKUN_BUSDEC_FAULT_EN, neither port SHALL exist and behaviour SHALL be otherwise identical.

Structure
REQ-026 A shared package ninjakun_pkg SHALL hold:
- the HWTYPE encodings;
- the CS index constants;
- the per-variant, per-CPU region base/mask table.
REQ-027 Decode SHALL sit in one sub-module, ninjakun_regdec, instantiated once per CPU; FSM, arbiter and counter stay in ninjakun_busdec.

Verification
REQ-028 NINJAKUN, WAITS=1, CP0REQ with CP0ADR=C000 -> CS=FGV bit one edge later; CP0WAIT high 2 cycles, then low in DONE.
REQ-029 RAIDERS5, both requests on the same edge (CP0ADR=8800, CP1ADR=E000) -> CPU0 granted first with CP1WAIT held; after CP0REQ falls, CPU1 is granted with CS=SCRX bit.
REQ-030 PKUNWAR, CP0ADR=4000 (miss) -> CP0WAIT stays 0 and CS stays 0.
REQ-031 CP0REQ dropped mid-ACC at WAITS=3 -> CS clears the next edge and the FSM returns to IDLE.
REQ-032 RST_N pulsed low during DONE -> CS=0 and CSOWN=0 asynchronously; the next simultaneous request grants CPU0.
REQ-033 FAULT_EN build, overlapping same-region hits for 300 cycles -> FAULT=1 and FAULTCNT=255.
